data_mem_unit: RTL and testbench

DATA_MEM_UNIT -- requirements
Module: data_mem_unit

---
 rtl/data_mem_unit_if.sv | 60 ++++++
 rtl/data_mem_unit.sv | 255 +++++++++++++++++++++++++
 tb/tb_data_mem_unit.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_unit_if.sv
// ---------------------------------------------------------------------------
// data_mem_unit_if
//
// Request/response bundle for the data memory unit.
//
// Parameters
//   DATA_W       data width in bits (32 or 64)
//
// Signals (master drives requests, slave drives responses)
//   MemRead      read request
//   memWrite     write request (wins over MemRead when both are set)
//   Address      byte address
//   write_data   store data, right-justified for sub-word stores
//   size         0 byte, 1 halfword, 2 word, 3 doubleword (64-bit only)
//   unsigned_ld  1 = zero-extend loads, 0 = sign-extend
//   read_data    load result, extended to DATA_W
//   read_valid   one-cycle pulse, read_data holds a new load result
//   mem_ready    unit accepts a request this cycle
//   access_err   one-cycle pulse, the previous request was rejected
// ---------------------------------------------------------------------------
interface data_mem_unit_if #(
    parameter int DATA_W = 32
);
    logic              MemRead;
    logic              memWrite;
    logic [31:0]       Address;
    logic [DATA_W-1:0] write_data;
    logic [1:0]        size;
    logic              unsigned_ld;
    logic [DATA_W-1:0] read_data;
    logic              read_valid;
    logic              mem_ready;
    logic              access_err;

    modport master (
        output MemRead,
        output memWrite,
        output Address,
        output write_data,
        output size,
        output unsigned_ld,
        input  read_data,
        input  read_valid,
        input  mem_ready,
        input  access_err
    );

    modport slave (
        input  MemRead,
        input  memWrite,
        input  Address,
        input  write_data,
        input  size,
        input  unsigned_ld,
        output read_data,
        output read_valid,
        output mem_ready,
        output access_err
    );
endinterface

// File: rtl/data_mem_unit.sv
// ---------------------------------------------------------------------------
// data_mem_unit
//
// Byte-addressable data memory with sub-word loads/stores, alignment and
// range checking, and a fixed read latency of READ_LAT cycles.
//
// Parameters
//   DATA_W    word width, 32 or 64
//   DEPTH     number of DATA_W-bit words, power of two
//   READ_LAT  cycles from read acceptance to read_valid, 1 or 2
//
// Ports
//   clk       single clock, rising edge
//   reset     asynchronous, active-high; clears control state and read_data
//             but never the memory array
//   bus       data_mem_unit_if slave modport (requests in, responses out)
//
// Behaviour summary
//   - mem_ready is high exactly while the FSM is IDLE. Requests seen while
//     busy are dropped, not queued.
//   - Writes complete at the accepting edge and keep the FSM in IDLE.
//   - Reads move to RD_WAIT and return to IDLE on the edge that raises
//     read_valid.
//   - Misaligned, out-of-range or unsupported-size requests produce a single
//     access_err pulse and have no other effect.
// ---------------------------------------------------------------------------
module data_mem_unit #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 1
) (
    input  logic            clk,
    input  logic            reset,
    data_mem_unit_if.slave  bus
);

    localparam int LANES    = DATA_W / 8;
    localparam int LANE_W   = $clog2(LANES);
    localparam int IDX_W    = $clog2(DEPTH);
    localparam int ADDR_USED = IDX_W + LANE_W;
    localparam logic LAT_LAST = 1'(READ_LAT - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t              state_q, state_d;
    logic                lat_cnt_q, lat_cnt_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [DATA_W-1:0]   read_data_q, read_data_d;
    logic                read_valid_q, read_valid_d;
    logic                access_err_q, access_err_d;

    // Memory array and its registered read port (block-RAM style).
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   ram_rd_q;

    // -----------------------------------------------------------------------
    // Request decode
    // -----------------------------------------------------------------------
    logic [IDX_W-1:0]    word_idx;
    logic [LANE_W-1:0]   lane;
    logic                ready;
    logic                req;
    logic                accept;
    logic                misaligned;
    logic                out_of_range;
    logic                size_bad;
    logic                bad;
    logic                wr_en;
    logic                rd_en;
    logic                reject;

    assign word_idx = bus.Address[ADDR_USED-1:LANE_W];
    assign lane     = bus.Address[LANE_W-1:0];
    assign ready    = (state_q == IDLE);
    assign req      = bus.MemRead | bus.memWrite;
    assign accept   = ready & req;

    // Alignment is judged on the full byte address, so a word access on a
    // 64-bit memory may sit in either half of the word.
    always_comb begin
        misaligned = 1'b0;
        case (bus.size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = bus.Address[0];
            2'd2:    misaligned = |bus.Address[1:0];
            default: misaligned = |bus.Address[2:0];
        endcase
    end

    // Any address bit above the word index must be zero; otherwise the
    // access would silently alias onto a lower word.
    assign out_of_range = ((bus.Address >> ADDR_USED) != 32'd0);
    assign size_bad     = (bus.size == 2'd3) && (DATA_W == 32);
    assign bad          = misaligned | out_of_range | size_bad;

    // A combined read+write request performs only the write.
    assign wr_en  = accept & bus.memWrite & ~bad;
    assign rd_en  = accept & bus.MemRead & ~bus.memWrite & ~bad;
    assign reject = accept & bad;

    // -----------------------------------------------------------------------
    // Store lane steering
    // -----------------------------------------------------------------------
    logic [LANES-1:0]    size_mask;
    logic [LANES-1:0]    byte_en;
    logic [DATA_W-1:0]   wdata_shifted;

    // Lane gi is part of the access when gi < 2**size bytes.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_size_mask
            assign size_mask[gi] = (32'(gi) < (32'd1 << bus.size));
        end
    endgenerate

    assign byte_en       = size_mask << lane;
    assign wdata_shifted = bus.write_data << {lane, 3'b000};

    // -----------------------------------------------------------------------
    // Memory array: byte-enabled write, registered read. No reset, so the
    // contents survive reset pulses.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < LANES; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][b*8 +: 8] <= wdata_shifted[b*8 +: 8];
                end
            end
        end
        if (rd_en) begin
            ram_rd_q <= mem[word_idx];
        end
    end

    // -----------------------------------------------------------------------
    // Load formatting: shift the selected lanes down to bit 0 and extend.
    // Uses the lane/size/signedness captured when the read was accepted,
    // since the request inputs may change while the read is in flight.
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0]   ld_shifted;
    logic [DATA_W-1:0]   keep_mask;
    logic                ld_sign;
    logic                ld_fill;
    logic [DATA_W-1:0]   ld_data;

    assign ld_shifted = ram_rd_q >> {lane_q, 3'b000};

    always_comb begin
        keep_mask = '1;
        ld_sign   = ld_shifted[DATA_W-1];
        case (size_q)
            2'd0: begin
                keep_mask = DATA_W'(32'h0000_00FF);
                ld_sign   = ld_shifted[7];
            end
            2'd1: begin
                keep_mask = DATA_W'(32'h0000_FFFF);
                ld_sign   = ld_shifted[15];
            end
            2'd2: begin
                keep_mask = DATA_W'(32'hFFFF_FFFF);
                ld_sign   = ld_shifted[31];
            end
            default: begin
                keep_mask = '1;
                ld_sign   = ld_shifted[DATA_W-1];
            end
        endcase
    end

    assign ld_fill = ld_sign & ~uns_q;
    assign ld_data = (ld_shifted & keep_mask) | ({DATA_W{ld_fill}} & ~keep_mask);

    // -----------------------------------------------------------------------
    // FSM: next state and registered outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        lane_d       = lane_q;
        size_d       = size_q;
        uns_d        = uns_q;
        read_data_d  = read_data_q;
        read_valid_d = 1'b0;
        access_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                access_err_d = reject;
                if (rd_en) begin
                    state_d   = RD_WAIT;
                    lat_cnt_d = 1'b0;
                    lane_d    = lane;
                    size_d    = bus.size;
                    uns_d     = bus.unsigned_ld;
                end
            end
            RD_WAIT: begin
                // The RAM output is already valid one edge after acceptance;
                // the counter only stretches the wait for READ_LAT = 2.
                if (lat_cnt_q == LAT_LAST) begin
                    state_d      = IDLE;
                    lat_cnt_d    = 1'b0;
                    read_valid_d = 1'b1;
                    read_data_d  = ld_data;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            lat_cnt_q    <= 1'b0;
            lane_q       <= '0;
            size_q       <= 2'd0;
            uns_q        <= 1'b0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            access_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            lane_q       <= lane_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            access_err_q <= access_err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.mem_ready  = ready;
    assign bus.read_data  = read_data_q;
    assign bus.read_valid = read_valid_q;
    assign bus.access_err = access_err_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// ---------------------------------------------------------------------------
// tb_data_mem_unit
//
// Directed bench for data_mem_unit. Two instances: u_dut (READ_LAT=1) takes
// the bulk of the vectors, u_dut2 (READ_LAT=2) covers the longer latency and
// the busy-while-request-held case. Stimulus pushes expected responses into
// queues; a negedge monitor pops and compares whenever a DUT raises
// read_valid or access_err.
// ---------------------------------------------------------------------------
module tb_data_mem_unit;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    data_mem_unit_if #(.DATA_W(32)) bus  ();
    data_mem_unit_if #(.DATA_W(32)) bus2 ();

    data_mem_unit #(.DATA_W(32), .DEPTH(1024), .READ_LAT(1)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    data_mem_unit #(.DATA_W(32), .DEPTH(1024), .READ_LAT(2)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    typedef struct {
        bit          is_err;
        logic [31:0] data;
    } exp_t;

    exp_t        q1[$];
    logic [31:0] q2[$];
    int          n_vec  = 0;
    int          n_miss = 0;
    logic [31:0] last_rd1 = 32'h0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // -----------------------------------------------------------------------
    // Monitor / scoreboard
    // -----------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            last_rd1 = 32'h0;
        end else begin
            if (bus.read_valid) begin
                if (q1.size() == 0) begin
                    n_vec++; n_miss++;
                    $display("FAIL unexpected_read_valid: read_data=0x%08h with no load outstanding (t=%0t)",
                             bus.read_data, $time);
                end else begin
                    e = q1.pop_front();
                    if (e.is_err) begin
                        n_vec++; n_miss++;
                        $display("FAIL resp_kind: got read_valid data=0x%08h, expected access_err (t=%0t)",
                                 bus.read_data, $time);
                    end else begin
                        check("load_data", bus.read_data, e.data);
                        $display("load   data=0x%08h expected=0x%08h", bus.read_data, e.data);
                    end
                end
                last_rd1 = bus.read_data;
            end else begin
                check("read_data_hold", bus.read_data, last_rd1);
            end

            if (bus.access_err) begin
                if (q1.size() == 0) begin
                    n_vec++; n_miss++;
                    $display("FAIL unexpected_access_err: no rejection outstanding (t=%0t)", $time);
                end else begin
                    e = q1.pop_front();
                    n_vec++;
                    if (!e.is_err) begin
                        n_miss++;
                        $display("FAIL resp_kind: got access_err, expected load data 0x%08h (t=%0t)",
                                 e.data, $time);
                    end else begin
                        $display("reject access_err seen as expected");
                    end
                end
            end

            if (bus2.read_valid) begin
                if (q2.size() == 0) begin
                    n_vec++; n_miss++;
                    $display("FAIL unexpected_read_valid_lat2: read_data=0x%08h (t=%0t)", bus2.read_data, $time);
                end else begin
                    check("load_data_lat2", bus2.read_data, q2.pop_front());
                    $display("load2  data=0x%08h", bus2.read_data);
                end
            end
            if (bus2.access_err) begin
                n_vec++; n_miss++;
                $display("FAIL unexpected_access_err_lat2 (t=%0t)", $time);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers (always entered and left at posedge + 1)
    // -----------------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ready();
        int i;
        i = 0;
        while (!bus.mem_ready && i < 20) begin
            @(posedge clk);
            #1;
            i++;
        end
        if (!bus.mem_ready) begin
            n_vec++; n_miss++;
            $display("FAIL mem_ready_timeout: mem_ready stayed 0 for 20 cycles");
        end
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [1:0] sz, input logic uns);
        wait_ready();
        bus.MemRead     = rd;
        bus.memWrite    = wr;
        bus.Address     = addr;
        bus.write_data  = wd;
        bus.size        = sz;
        bus.unsigned_ld = uns;
        @(posedge clk);
        #1;
        bus.MemRead  = 1'b0;
        bus.memWrite = 1'b0;
    endtask

    task automatic wr_req(input logic [31:0] addr, input logic [31:0] wd, input logic [1:0] sz);
        $display("write  addr=0x%08h data=0x%08h size=%0d", addr, wd, sz);
        issue(1'b0, 1'b1, addr, wd, sz, 1'b0);
    endtask

    task automatic rd_req(input logic [31:0] addr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] exp);
        exp_t e;
        e.is_err = 1'b0;
        e.data   = exp;
        q1.push_back(e);
        issue(1'b1, 1'b0, addr, 32'h0, sz, uns);
    endtask

    task automatic bad_req(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [1:0] sz);
        exp_t e;
        e.is_err = 1'b1;
        e.data   = 32'h0;
        q1.push_back(e);
        $display("badreq rd=%0b wr=%0b addr=0x%08h size=%0d", rd, wr, addr, sz);
        issue(rd, wr, addr, 32'hFFFF_FFFF, sz, 1'b0);
    endtask

    // -----------------------------------------------------------------------
    // Directed sequence
    // -----------------------------------------------------------------------
    initial begin
        reset = 1'b1;
        bus.MemRead = 1'b0;  bus.memWrite = 1'b0;  bus.Address = 32'h0;
        bus.write_data = 32'h0;  bus.size = 2'd0;  bus.unsigned_ld = 1'b0;
        bus2.MemRead = 1'b0; bus2.memWrite = 1'b0; bus2.Address = 32'h0;
        bus2.write_data = 32'h0; bus2.size = 2'd0; bus2.unsigned_ld = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_read_data",  bus.read_data, 32'h0);
        check("rst_read_valid", 32'(bus.read_valid), 32'h0);
        check("rst_access_err", 32'(bus.access_err), 32'h0);
        check("rst_mem_ready",  32'(bus.mem_ready), 32'h1);
        check("rst_mem_ready2", 32'(bus2.mem_ready), 32'h1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Word write then read, with exact handshake timing
        wr_req(32'h10, 32'hDEAD_BEEF, 2'd2);
        rd_req(32'h10, 2'd2, 1'b0, 32'hDEAD_BEEF);
        check("busy_after_accept", 32'(bus.mem_ready), 32'h0);
        check("no_valid_yet",      32'(bus.read_valid), 32'h0);
        @(posedge clk);
        #1;
        check("valid_after_lat1",  32'(bus.read_valid), 32'h1);
        check("ready_after_lat1",  32'(bus.mem_ready), 32'h1);

        // Byte store, read-after-write to the same word, sub-word loads
        wr_req(32'h12, 32'h0000_005A, 2'd0);
        rd_req(32'h10, 2'd2, 1'b0, 32'hDE5A_BEEF);
        rd_req(32'h13, 2'd0, 1'b0, 32'hFFFF_FFDE);
        rd_req(32'h13, 2'd0, 1'b1, 32'h0000_00DE);

        // Rejections: memory, read_data and FSM unaffected
        wr_req(32'h0, 32'h0102_0304, 2'd2);
        bad_req(1'b1, 1'b0, 32'h11, 2'd1);
        bad_req(1'b0, 1'b1, 32'h12, 2'd2);
        bad_req(1'b1, 1'b0, 32'h10, 2'd3);
        bad_req(1'b1, 1'b0, 32'h1000, 2'd2);
        bad_req(1'b0, 1'b1, 32'h1000, 2'd2);
        idle(2);
        check("read_data_after_rejects", bus.read_data, 32'h0000_00DE);
        rd_req(32'h10, 2'd2, 1'b0, 32'hDE5A_BEEF);
        rd_req(32'h0,  2'd2, 1'b0, 32'h0102_0304);
        rd_req(32'h12, 2'd1, 1'b1, 32'h0000_DE5A);
        rd_req(32'h12, 2'd1, 1'b0, 32'hFFFF_DE5A);

        // Read and write together: only the write happens
        $display("rdwr   addr=0x00000020 data=0x12345678");
        issue(1'b1, 1'b1, 32'h20, 32'h1234_5678, 2'd2, 1'b0);
        idle(2);
        rd_req(32'h20, 2'd2, 1'b0, 32'h1234_5678);

        // Halfword store, byte store with junk upper data bits
        wr_req(32'h22, 32'h0000_8001, 2'd1);
        rd_req(32'h22, 2'd1, 1'b0, 32'hFFFF_8001);
        rd_req(32'h20, 2'd1, 1'b1, 32'h0000_5678);
        rd_req(32'h21, 2'd0, 1'b0, 32'h0000_0056);
        wr_req(32'h21, 32'hFFFF_FFAB, 2'd0);
        rd_req(32'h20, 2'd2, 1'b0, 32'h8001_AB78);

        // Reset while a read is in flight aborts it
        wait_ready();
        bus.MemRead = 1'b1; bus.Address = 32'h10; bus.size = 2'd2; bus.unsigned_ld = 1'b0;
        @(posedge clk);
        #1;
        bus.MemRead = 1'b0;
        check("in_rd_wait", 32'(bus.mem_ready), 32'h0);
        reset = 1'b1;
        #1;
        check("async_rst_read_data", bus.read_data, 32'h0);
        check("async_rst_mem_ready", 32'(bus.mem_ready), 32'h1);
        check("async_rst_valid",     32'(bus.read_valid), 32'h0);
        $display("reset  asserted during RD_WAIT");
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(3);
        rd_req(32'h10, 2'd2, 1'b0, 32'hDE5A_BEEF);
        idle(3);

        // READ_LAT = 2 instance: latency and held request while busy
        bus2.memWrite = 1'b1; bus2.Address = 32'h10; bus2.write_data = 32'hCAFE_F00D; bus2.size = 2'd2;
        @(posedge clk);
        #1;
        bus2.Address = 32'h14; bus2.write_data = 32'h0BAD_F00D;
        @(posedge clk);
        #1;
        bus2.memWrite = 1'b0;
        q2.push_back(32'hCAFE_F00D);
        q2.push_back(32'h0BAD_F00D);
        bus2.MemRead = 1'b1; bus2.Address = 32'h10;
        @(posedge clk);                        // first read accepted
        #1;
        bus2.Address = 32'h14;                 // ignored until mem_ready returns
        check("lat2_busy0", 32'(bus2.mem_ready), 32'h0);
        @(posedge clk);
        #1;
        check("lat2_busy1",   32'(bus2.mem_ready), 32'h0);
        check("lat2_novalid", 32'(bus2.read_valid), 32'h0);
        @(posedge clk);
        #1;
        check("lat2_valid",   32'(bus2.read_valid), 32'h1);
        check("lat2_ready",   32'(bus2.mem_ready), 32'h1);
        @(posedge clk);                        // second read accepted
        #1;
        check("lat2_busy2",    32'(bus2.mem_ready), 32'h0);
        check("lat2_pulse1cy", 32'(bus2.read_valid), 32'h0);
        @(posedge clk);
        #1;
        check("lat2_novalid2", 32'(bus2.read_valid), 32'h0);
        @(posedge clk);
        #1;
        check("lat2_valid2",   32'(bus2.read_valid), 32'h1);
        bus2.MemRead = 1'b0;
        idle(4);

        check("q1_drained", 32'(q1.size()), 32'h0);
        check("q2_drained", 32'(q2.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
